mmu_ctrl: RTL and testbench

MMU_CTRL -- requirements
Module: mmu_ctrl

---
 rtl/mmu_pkg.sv | 16 +
 rtl/mmu_ctrl.sv | 139 +++++++++++++
 tb/tb_mmu_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared FSM state type and default widths for the MMU tile controller
package mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } mmu_state_e;

  localparam int MMU_DATA_WIDTH = 16;
  localparam int MMU_FIXED_PNT  = 8;

endpackage

// File: rtl/mmu_ctrl.sv
// rtl/mmu_ctrl.sv - sequences K-tiles through an external matrix multiplier and accumulates the result
module mmu_ctrl
  import mmu_pkg::*;
#(
  parameter int NUM_ROWS_A = 1,
  parameter int NUM_COLS_A = 1,
  parameter int NUM_COLS_B = 1,
  parameter int DATA_WIDTH = MMU_DATA_WIDTH,
  parameter int FIXED_PNT  = MMU_FIXED_PNT,
  parameter int MAX_TILES  = 16,
  parameter int TIMEOUT    = 8,
  localparam int CNT_W = $clog2(MAX_TILES + 1),
  localparam int IDX_W = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1,
  localparam int TMO_W = $clog2(TIMEOUT + 1)
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [CNT_W-1:0]                                      num_tiles,
  output logic                                                  tile_req,
  output logic [IDX_W-1:0]                                      tile_idx,
  input  logic                                                  tile_valid,
  input  logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] tile_a,
  input  logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] tile_b,
  output logic                                                  mmu_enable,
  output logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mmu_mat_in1,
  output logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in2,
  output logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in_accum,
  input  logic                                                  mmu_data_ready,
  input  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_out,
  output logic                                                  res_valid,
  input  logic                                                  res_ready,
  output logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] res_mat,
  output logic                                                  busy,
  output logic                                                  err
);

  mmu_state_e state_q, state_d;
  logic [CNT_W-1:0] ntiles_q, ntiles_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] a_q, a_d;
  logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] b_q, b_d;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] k_next;

  assign k_next = CNT_W'(k_q) + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    ntiles_d = ntiles_q;
    k_d      = k_q;
    tmo_d    = tmo_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ntiles_d = num_tiles;
          k_d      = '0;
          tmo_d    = '0;
          acc_d    = '0;
          state_d  = (num_tiles == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (tile_valid) begin
          a_d     = tile_a;
          b_d     = tile_b;
          tmo_d   = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        // A missing completion pulse abandons the whole job; nothing partial is returned.
        if (mmu_data_ready) begin
          state_d = ST_CAPTURE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CAPTURE: begin
        acc_d   = mmu_mat_out;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        k_d     = k_q + IDX_W'(1);
        state_d = (k_next < ntiles_q) ? ST_FETCH : ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ntiles_q <= '0;
      k_q      <= '0;
      tmo_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ntiles_q <= ntiles_d;
      k_q      <= k_d;
      tmo_q    <= tmo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
    end
  end

  // Enable stays high through CAPTURE and drops only in GAP, giving the multiplier a fresh rising edge per tile.
  assign mmu_enable       = (state_q == ST_COMPUTE) || (state_q == ST_CAPTURE);
  assign tile_req         = (state_q == ST_FETCH);
  assign tile_idx         = k_q;
  assign mmu_mat_in1      = a_q;
  assign mmu_mat_in2      = b_q;
  assign mmu_mat_in_accum = acc_q;
  assign res_valid        = (state_q == ST_DONE);
  assign res_mat          = (state_q == ST_DONE) ? acc_q : '0;
  assign busy             = (state_q != ST_IDLE);
  assign err              = err_q;

endmodule

// File: tb/tb_mmu_ctrl.sv
// tb/tb_mmu_ctrl.sv - directed self-checking bench for mmu_ctrl with a behavioural multiplier and tile source
module tb_mmu_ctrl;
  import mmu_pkg::*;

  localparam int TMO = 8;
  localparam int CW  = $clog2(16 + 1);
  localparam int IW  = $clog2(16);

  typedef logic [1:0][1:0][15:0] mat_t;

  localparam mat_t M_IDENT = 64'h0100_0000_0000_0100;
  localparam mat_t M_ONES  = 64'h0100_0100_0100_0100;
  localparam mat_t M_B1    = 64'h0300_0080_0100_0200;
  localparam mat_t M_TWOS  = 64'h0200_0200_0200_0200;
  localparam mat_t M_THREE = 64'h0300_0300_0300_0300;

  logic clk = 1'b0;
  logic rst_n, start, tile_req, tile_valid, mmu_enable, mmu_data_ready;
  logic res_valid, res_ready, busy, err;
  logic [CW-1:0] num_tiles;
  logic [IW-1:0] tile_idx;
  mat_t tile_a, tile_b, in1, in2, accum, res_mat;
  mat_t mat_out = '0;

  mmu_ctrl #(
    .NUM_ROWS_A(2), .NUM_COLS_A(2), .NUM_COLS_B(2), .DATA_WIDTH(16),
    .FIXED_PNT(8), .MAX_TILES(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .tile_req(tile_req), .tile_idx(tile_idx), .tile_valid(tile_valid),
    .tile_a(tile_a), .tile_b(tile_b), .mmu_enable(mmu_enable),
    .mmu_mat_in1(in1), .mmu_mat_in2(in2), .mmu_mat_in_accum(accum),
    .mmu_data_ready(mmu_data_ready), .mmu_mat_out(mat_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_mat(res_mat),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mat_t mult(input mat_t a, input mat_t b, input mat_t acc);
    mat_t r;
    int s;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        r[i][j] = 16'((s >>> 8) + int'($signed(acc[i][j])));
      end
    end
    return r;
  endfunction

  // Zero-wait tile source plus a multiplier that pulses ready two cycles after enable rises.
  mat_t ta[3];
  mat_t tbm[3];
  bit   model_off = 1'b0;
  logic en_prev = 1'b0;
  int   mcnt = 0;
  always @(negedge clk) begin
    tile_valid = tile_req;
    tile_a = ta[int'(tile_idx) % 3];
    tile_b = tbm[int'(tile_idx) % 3];
    mmu_data_ready = 1'b0;
    if (mmu_enable === 1'b1 && en_prev !== 1'b1) begin
      mcnt = 1;
    end else if (mmu_enable === 1'b1 && mcnt > 0) begin
      if (mcnt == 2 && !model_off) begin
        mmu_data_ready = 1'b1;
        mat_out = mult(in1, in2, accum);
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
    en_prev = mmu_enable;
  end

  task automatic run_job(input string nm, input int nt, input mat_t exp_res, input int exp_gaps, input int hold);
    int s, v, low, gaps;
    bit en_seen, req_seen, stable;
    mat_t snap;
    num_tiles = CW'(nt);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    v = -1; low = 0; gaps = 0; en_seen = 0; req_seen = 0;
    for (int i = 0; i < 300 && v < 0; i++) begin
      if (res_valid) begin
        v = cyc;
      end else begin
        en_seen |= mmu_enable;
        req_seen |= tile_req;
        if (!mmu_enable && !tile_req && busy) low++;
        if (mmu_enable && low > 0) begin
          check({nm, "_gap_len"}, low, 1);
          gaps++;
          low = 0;
        end
        @(negedge clk);
      end
    end
    check({nm, "_done"}, (v >= 0), 1);
    if (v >= 0) begin
      check({nm, "_latency"}, v - s - 1, 6 * nt);
      check({nm, "_res"}, res_mat, exp_res);
      check({nm, "_gaps"}, gaps, exp_gaps);
      if (nt == 0) begin
        check({nm, "_req_seen"}, req_seen, 0);
        check({nm, "_en_seen"}, en_seen, 0);
      end
      snap = res_mat;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        start = (h == 3);
        num_tiles = CW'(1);
        @(negedge clk);
        if (res_mat !== snap || res_valid !== 1'b1) stable = 1'b0;
      end
      start = 1'b0;
      if (hold > 0) check({nm, "_hold_stable"}, stable, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({nm, "_busy_after"}, busy, 0);
      check({nm, "_valid_after"}, res_valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: still running at %0t, expected finish earlier", $time);
    $fatal;
  end

  initial begin
    int s, e;
    bit rv, hit;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; num_tiles = '0;
    for (int i = 0; i < 3; i++) begin ta[i] = M_IDENT; tbm[i] = M_ONES; end
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, mmu_enable, tile_req, res_valid, err}, 0);
    check("rst_idx", tile_idx, 0);
    check("rst_res", res_mat, 0);
    check("rst_ops", {in1, in2, accum}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    ta[0] = M_IDENT; tbm[0] = M_B1;
    run_job("s1", 1, M_B1, 0, 0);

    for (int i = 0; i < 3; i++) begin ta[i] = M_IDENT; tbm[i] = M_ONES; end
    run_job("s2", 3, M_THREE, 2, 0);

    run_job("s3", 0, '0, 0, 0);

    model_off = 1'b1;
    num_tiles = CW'(1);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    e = -1; rv = 0;
    for (int i = 0; i < 60 && e < 0; i++) begin
      if (res_valid) rv = 1;
      if (err) e = cyc;
      else @(negedge clk);
    end
    check("tmo_seen", (e >= 0), 1);
    check("tmo_cycle", e - s, 2 + TMO);
    check("tmo_busy", busy, 0);
    check("tmo_enable", mmu_enable, 0);
    check("tmo_no_valid", rv, 0);
    @(negedge clk);
    check("tmo_err_pulse", err, 0);
    model_off = 1'b0;
    @(negedge clk);

    run_job("s5", 1, M_ONES, 0, 10);
    @(negedge clk);
    check("s5_start_ignored", busy, 0);

    num_tiles = CW'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (tile_idx == IW'(1) && mmu_enable) hit = 1;
      else @(negedge clk);
    end
    check("s6_reach_tile2", hit, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("s6_rst_ctrl", {busy, mmu_enable, tile_req, res_valid, err}, 0);
    check("s6_rst_idx", tile_idx, 0);
    check("s6_rst_res", res_mat, 0);
    check("s6_rst_ops", {in1, in2, accum}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_no_err", {err, busy, res_valid}, 0);
    run_job("s6b", 2, M_TWOS, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
